reg_window_ctrl: RTL and testbench

- Register-window controller that sits directly upstream of the windowed 8 x 16-bit register file and drives its window base (sig_wnd) and write strobe.
- Handles call/return window moves from the decode stage.
- When a call would overwrite the oldest resident window, it spills 2 registers to a backing memory stack. When a return lands on a spilled window, it fills 2 registers back.
- Window geometry is fixed: 4 registers per window, step 2, 8 physical registers, at most 3 resident windows.

---
 rtl/reg_window_pkg.sv | 26 ++
 rtl/reg_window_xfer.sv | 56 +++++
 rtl/reg_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_reg_window_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_window_pkg.sv
// Shared window geometry, FSM state codes and the spill/fill RF base helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_window_pkg;

    localparam int NUM_PHYS = 8;
    localparam int WND_SIZE = 4;
    localparam int WND_STEP = 2;
    localparam int MAX_RES  = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SPILL0   = 3'd1;
    localparam logic [2:0] ST_SPILL1   = 3'd2;
    localparam logic [2:0] ST_FILL0    = 3'd3;
    localparam logic [2:0] ST_FILL1    = 3'd4;
    localparam logic [2:0] ST_FILL_WR0 = 3'd5;
    localparam logic [2:0] ST_FILL_WR1 = 3'd6;

    // Spills address the window being entered, fills the window being restored.
    function automatic logic [2:0] xfer_base(input logic [2:0] wnd, input logic is_fill);
        xfer_base = is_fill ? (wnd - 3'(WND_STEP)) : (wnd + 3'(WND_STEP));
    endfunction

endpackage

// File: rtl/reg_window_xfer.sv
// Two-word backing-memory handshake sequencer shared by spill and fill.
// Latency: each word holds mem_req_o until mem_ack_i; fill data is latched on its ack.
// Backpressure: the controller FSM stalls in its word state until word_done.
module reg_window_xfer
    import reg_window_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input  logic [MEM_AW-1:0] sp,
    input  logic [DATA_W-1:0] rf_rdata_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              word_done,
    output logic [DATA_W-1:0] fill_dat
);

    logic              is_spill;
    logic              is_fill;
    logic [MEM_AW-1:0] word_off;

    assign is_spill  = (state == ST_SPILL0) || (state == ST_SPILL1);
    assign is_fill   = (state == ST_FILL0)  || (state == ST_FILL1);
    assign word_off  = MEM_AW'((state == ST_SPILL1) || (state == ST_FILL1));

    assign mem_req_o   = is_spill || is_fill;
    assign mem_we_o    = is_spill;
    assign mem_wdata_o = is_spill ? rf_rdata_i : '0;
    assign word_done   = mem_req_o && mem_ack_i;

    // Spill pushes at sp, sp+1; fill pops the pair just below sp.
    always_comb begin
        mem_addr_o = '0;
        if (is_spill) begin
            mem_addr_o = sp + word_off;
        end else if (is_fill) begin
            mem_addr_o = sp - MEM_AW'(WND_STEP) + word_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_dat <= '0;
        end else if (word_done && is_fill) begin
            fill_dat <= mem_rdata_i;
        end
    end

endmodule

// File: rtl/reg_window_ctrl.sv
// Register-window call/return controller with spill/fill to a backing stack; REG_WND_STATS_EN adds spill/fill counters.
// Latency: zero-stall moves update wnd next edge; spill/fill take >=2 words x (1 + ack wait), fill +2 RF writes.
// Backpressure: busy_o stalls decode; requests while busy are dropped and flagged on err_o.
module reg_window_ctrl
    import reg_window_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MEM_AW  = 8,
    parameter int DEPTH_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              call_i,
    input  logic              ret_i,
    output logic              busy_o,
    output logic              err_o,
`ifdef REG_WND_STATS_EN
    output logic [15:0]       spill_cnt_o,
    output logic [15:0]       fill_cnt_o,
`endif
    output logic [2:0]        rf_wnd_o,
    output logic [1:0]        rf_addr_o,
    output logic              rf_we_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    logic [2:0]         state;
    logic [2:0]         wnd;
    logic [DEPTH_W-1:0] depth;
    logic [1:0]         resident;
    logic [MEM_AW-1:0]  sp;
    logic               err_q;
    logic               word_done;

    reg_window_xfer #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_xfer (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .sp          (sp),
        .rf_rdata_i  (rf_rdata_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .word_done   (word_done),
        .fill_dat    (rf_wdata_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wnd      <= '0;
            depth    <= '0;
            resident <= 2'd1;
            sp       <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (call_i && ret_i) begin
                        err_q <= 1'b1;
                    end else if (call_i) begin
                        if (depth == DEPTH_MAX) begin
                            err_q <= 1'b1;
                        end else if (resident < 2'(MAX_RES)) begin
                            wnd      <= wnd + 3'(WND_STEP);
                            depth    <= depth + 1'b1;
                            resident <= resident + 2'd1;
                        end else begin
                            state <= ST_SPILL0;
                        end
                    end else if (ret_i) begin
                        if (depth == '0) begin
                            err_q <= 1'b1;
                        end else if (resident > 2'd1) begin
                            wnd      <= wnd - 3'(WND_STEP);
                            depth    <= depth - 1'b1;
                            resident <= resident - 2'd1;
                        end else begin
                            state <= ST_FILL0;
                        end
                    end
                end
                ST_SPILL0: if (word_done) state <= ST_SPILL1;
                ST_SPILL1: begin
                    if (word_done) begin
                        state <= ST_IDLE;
                        wnd   <= wnd + 3'(WND_STEP);
                        depth <= depth + 1'b1;
                        sp    <= sp + MEM_AW'(WND_STEP);
                    end
                end
                ST_FILL0:    if (word_done) state <= ST_FILL_WR0;
                ST_FILL_WR0: state <= ST_FILL1;
                ST_FILL1:    if (word_done) state <= ST_FILL_WR1;
                ST_FILL_WR1: begin
                    state <= ST_IDLE;
                    wnd   <= wnd - 3'(WND_STEP);
                    depth <= depth - 1'b1;
                    sp    <= sp - MEM_AW'(WND_STEP);
                end
                default: state <= ST_IDLE;
            endcase
            if ((state != ST_IDLE) && (call_i || ret_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Spill reads offsets 2/3 of the incoming window, i.e. the oldest window's 0/1.
    always_comb begin
        rf_wnd_o  = wnd;
        rf_addr_o = 2'd0;
        case (state)
            ST_SPILL0: begin
                rf_wnd_o  = xfer_base(wnd, 1'b0);
                rf_addr_o = 2'd2;
            end
            ST_SPILL1: begin
                rf_wnd_o  = xfer_base(wnd, 1'b0);
                rf_addr_o = 2'd3;
            end
            ST_FILL0, ST_FILL_WR0: begin
                rf_wnd_o  = xfer_base(wnd, 1'b1);
                rf_addr_o = 2'd0;
            end
            ST_FILL1, ST_FILL_WR1: begin
                rf_wnd_o  = xfer_base(wnd, 1'b1);
                rf_addr_o = 2'd1;
            end
            default: ;
        endcase
    end

    assign rf_we_o = (state == ST_FILL_WR0) || (state == ST_FILL_WR1);
    assign busy_o  = (state != ST_IDLE);
    assign err_o   = err_q;

`ifdef REG_WND_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spill_cnt_o <= '0;
            fill_cnt_o  <= '0;
        end else begin
            if ((state == ST_SPILL1) && word_done && (spill_cnt_o != 16'hFFFF)) begin
                spill_cnt_o <= spill_cnt_o + 16'd1;
            end
            if ((state == ST_FILL_WR1) && (fill_cnt_o != 16'hFFFF)) begin
                fill_cnt_o <= fill_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_window_ctrl.sv
// Bench for reg_window_ctrl: RF and backing-memory models, window-stack reference model.
module tb_reg_window_ctrl;

    localparam int DATA_W  = 16;
    localparam int MEM_AW  = 8;
    localparam int DEPTH_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              call_i = 1'b0;
    logic              ret_i = 1'b0;
    logic              busy_o, err_o;
    logic [2:0]        rf_wnd_o;
    logic [1:0]        rf_addr_o;
    logic              rf_we_o;
    logic [DATA_W-1:0] rf_wdata_o, rf_rdata_i;
    logic              mem_req_o, mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;
    logic              mem_ack_i;
`ifdef REG_WND_STATS_EN
    logic [15:0]       spill_cnt_o, fill_cnt_o;
`endif

    always #5 clk = ~clk;

    reg_window_ctrl #(
        .DATA_W  (DATA_W),
        .MEM_AW  (MEM_AW),
        .DEPTH_W (DEPTH_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_i      (call_i),
        .ret_i       (ret_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
`ifdef REG_WND_STATS_EN
        .spill_cnt_o (spill_cnt_o),
        .fill_cnt_o  (fill_cnt_o),
`endif
        .rf_wnd_o    (rf_wnd_o),
        .rf_addr_o   (rf_addr_o),
        .rf_we_o     (rf_we_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_rdata_i  (rf_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    // Windowed register file: physical index = base + offset (mod 8); contents reseeded during reset.
    logic [DATA_W-1:0] rf [8];
    assign rf_rdata_i = rf[rf_wnd_o + {1'b0, rf_addr_o}];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= DATA_W'($urandom);
        end else if (rf_we_o) begin
            rf[rf_wnd_o + {1'b0, rf_addr_o}] <= rf_wdata_o;
        end
    end

    // Backing memory responder with programmable ack wait; every completed word is logged.
    logic [DATA_W-1:0] mem [256];
    int                ack_dly = 0;
    int                wait_cnt;
    logic [MEM_AW-1:0] log_addr [$];
    logic              log_we   [$];
    logic [DATA_W-1:0] log_dat  [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack_i   <= 1'b0;
            mem_rdata_i <= '0;
            wait_cnt    <= 0;
        end else begin
            mem_ack_i <= 1'b0;
            if (mem_req_o && mem_ack_i) begin
                log_addr.push_back(mem_addr_o);
                log_we.push_back(mem_we_o);
                log_dat.push_back(mem_wdata_o);
                if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
                wait_cnt <= 0;
            end else if (mem_req_o) begin
                if (wait_cnt >= ack_dly) begin
                    mem_ack_i   <= 1'b1;
                    mem_rdata_i <= mem[mem_addr_o];
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: nesting depth, resident count, stack pointer and a LIFO of spilled pairs.
    int                m_depth, m_res, m_sp, m_spills, m_fills;
    logic [DATA_W-1:0] m_stack [$];

    task automatic model_reset();
        m_depth = 0; m_res = 1; m_sp = 0; m_spills = 0; m_fills = 0;
        m_stack.delete();
    endtask

    task automatic do_op(input bit c, input bit r, input bit poke);
        bit                exp_err, exp_spill, exp_fill;
        logic [DATA_W-1:0] snap [8];
        logic [DATA_W-1:0] v0, v1;
        int                lb, ob, cyc;
        snap      = rf;
        exp_err   = (c && r) || (c && !r && m_depth == 15) || (r && !c && m_depth == 0);
        exp_spill = c && !r && !exp_err && m_res == 3;
        exp_fill  = r && !c && !exp_err && m_res == 1;
        lb        = log_addr.size();
        call_i = c; ret_i = r;
        @(posedge clk); #1;
        call_i = 1'b0; ret_i = 1'b0;
        chk("err_pulse", err_o, exp_err);
        chk("busy_start", busy_o, exp_spill || exp_fill);
        if (poke) begin
            call_i = 1'b1;
            @(posedge clk); #1;
            call_i = 1'b0;
            chk("err_req_while_busy", err_o, 1);
        end
        cyc = 0;
        while (busy_o && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_timeout", busy_o, 0);
        if (exp_spill) begin
            ob = (2 * (m_depth - 2)) & 7;
            chk("spill_words", log_addr.size(), lb + 2);
            if (log_addr.size() >= lb + 2) begin
                chk("spill_addr0", log_addr[lb],     m_sp & 255);
                chk("spill_addr1", log_addr[lb + 1], (m_sp + 1) & 255);
                chk("spill_we",    {log_we[lb], log_we[lb + 1]}, 2'b11);
                chk("spill_dat0",  log_dat[lb],     snap[ob]);
                chk("spill_dat1",  log_dat[lb + 1], snap[(ob + 1) & 7]);
            end
            m_stack.push_back(snap[ob]);
            m_stack.push_back(snap[(ob + 1) & 7]);
            m_sp = (m_sp + 2) & 255;
            m_spills++;
        end else if (exp_fill) begin
            v1 = m_stack.pop_back();
            v0 = m_stack.pop_back();
            ob = (2 * (m_depth - 1)) & 7;
            chk("fill_words", log_addr.size(), lb + 2);
            if (log_addr.size() >= lb + 2) begin
                chk("fill_addr0", log_addr[lb],     (m_sp - 2) & 255);
                chk("fill_addr1", log_addr[lb + 1], (m_sp - 1) & 255);
                chk("fill_we",    {log_we[lb], log_we[lb + 1]}, 2'b00);
            end
            chk("fill_rf0", rf[ob],           v0);
            chk("fill_rf1", rf[(ob + 1) & 7], v1);
            m_sp = (m_sp - 2) & 255;
            m_fills++;
        end else begin
            chk("no_mem_traffic", log_addr.size(), lb);
        end
        if (!exp_err && c) begin
            m_depth++;
            if (!exp_spill) m_res++;
        end else if (!exp_err && r) begin
            m_depth--;
            if (!exp_fill) m_res--;
        end
        @(posedge clk); #1;
        chk("err_clear", err_o, 0);
        chk("wnd", rf_wnd_o, (2 * m_depth) & 7);
`ifdef REG_WND_STATS_EN
        chk("spill_cnt", spill_cnt_o, m_spills);
        chk("fill_cnt", fill_cnt_o, m_fills);
`endif
    endtask

    initial begin
        int lb, cyc, k;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_wnd", rf_wnd_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_rf_wdata", rf_wdata_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset abandons a spill in its second word.
        ack_dly = 3;
        do_op(1'b1, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 1'b0);
        lb = log_addr.size();
        call_i = 1'b1;
        @(posedge clk); #1;
        call_i = 1'b0;
        cyc = 0;
        while (log_addr.size() < lb + 1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("mid_spill_busy", busy_o, 1);
        chk("mid_spill_req", mem_req_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", mem_req_o, 0);
        chk("rst_async_busy", busy_o, 0);
        chk("rst_async_wnd", rf_wnd_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
`ifdef REG_WND_STATS_EN
        chk("rst_spill_cnt", spill_cnt_o, 0);
        chk("rst_fill_cnt", fill_cnt_o, 0);
`endif

        // Illegal requests at depth 0.
        do_op(1'b0, 1'b1, 1'b0);
        do_op(1'b1, 1'b1, 1'b0);

        // Two zero-stall calls, a slow spill with a request poked mid-spill, then three returns.
        ack_dly = 3;
        do_op(1'b1, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, 1'b1);
        do_op(1'b0, 1'b1, 1'b0);
        do_op(1'b0, 1'b1, 1'b0);
        do_op(1'b0, 1'b1, 1'b0);

        // Run to maximum depth and back, overflowing and underflowing once each.
        for (int i = 0; i < 16; i++) begin
            ack_dly = $urandom_range(0, 3);
            do_op(1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            ack_dly = $urandom_range(0, 3);
            do_op(1'b0, 1'b1, 1'b0);
        end

        // Random mix of calls, returns and simultaneous requests.
        for (int i = 0; i < 80; i++) begin
            ack_dly = $urandom_range(0, 3);
            k = $urandom_range(0, 9);
            if (k == 0)     do_op(1'b1, 1'b1, 1'b0);
            else if (k < 6) do_op(1'b1, 1'b0, 1'b0);
            else            do_op(1'b0, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
